// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LSU memory port arbiter.
//   arb_state_e : arbiter FSM states
//   arb_src_e   : which requester owns the in-flight transaction
//   mem_req_t   : latched bus request payload
// Optional feature macro used by the design: MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_LSU = 1'b1
    } arb_src_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection between IF and LSU requesters.
// Ports:
//   clk_i, rst_i  clock / async active-high reset (used only by the starvation guard)
//   if_valid_i    IF request pending
//   ls_valid_i    LSU request pending
//   accept_i      a request is being granted this cycle
//   grant_ls_o    1 = LSU wins, 0 = IF wins (meaningful only while accept_i)
// Macro MEM_ARB_STARVE_GUARD_EN: when defined, a saturating LSU streak counter
// hands the grant to IF after MAX_LSU_STREAK consecutive LSU wins over a waiting IF.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_valid_i,
    input  logic ls_valid_i,
    input  logic accept_i,
    output logic grant_ls_o
);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STREAK_W = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                force_if;

    assign force_if   = if_valid_i && (streak_q == STREAK_MAX);
    assign grant_ls_o = ls_valid_i && !force_if;

    // Count LSU wins only while IF is actually being held off; anything else restarts.
    always_comb begin
        streak_d = streak_q;
        if (accept_i) begin
            if (grant_ls_o && if_valid_i) begin
                if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    // Strict LSU priority; the remaining inputs have no use here.
    logic unused_guard;
    assign unused_guard = ^{clk_i, rst_i, if_valid_i, accept_i};
    assign grant_ls_o   = ls_valid_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory/IO bus between instruction fetch (IF) and
// load/store (LSU). One outstanding transaction: IDLE -> ISSUE -> WAIT -> IDLE.
// Ports:
//   clk_i, rst_i                      clock / async active-high reset
//   if_req_valid_i/ready_o, if_addr_i IF read request
//   if_rsp_valid_o                    IF response pulse
//   ls_req_valid_i/ready_o, ls_*      LSU load/store request
//   ls_rsp_valid_o                    LSU load data / store ack pulse
//   rsp_rdata_o                       registered response data (both requesters)
//   bus_req_*                         latched bus request with valid/ready handshake
//   bus_rsp_valid_i, bus_rdata_i      bus response
// ADDR_W/DATA_W must match the widths in mem_arb_pkg.
// Macro MEM_ARB_STARVE_GUARD_EN enables the IF starvation guard in mem_arb_grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = MEM_ADDR_W,
    parameter int unsigned DATA_W         = MEM_DATA_W,
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_rsp_valid_o,
    input  logic                ls_req_valid_i,
    output logic                ls_req_ready_o,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic                ls_we_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    output logic                ls_rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                bus_req_valid_o,
    input  logic                bus_req_ready_i,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_be_o,
    input  logic                bus_rsp_valid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    arb_state_e        state_q, state_d;
    arb_src_e          src_q, src_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              if_rsp_valid_q, if_rsp_valid_d;
    logic              ls_rsp_valid_q, ls_rsp_valid_d;
    logic              accept;
    logic              grant_ls;

    // Ready is combinational so the winner sees acceptance in the same cycle;
    // gated by reset so nothing is offered while the block is held in reset.
    assign accept = (state_q == ARB_IDLE) && !rst_i && (if_req_valid_i || ls_req_valid_i);

    mem_arb_grant #(
        .MAX_LSU_STREAK (MAX_LSU_STREAK)
    ) u_grant (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_valid_i (if_req_valid_i),
        .ls_valid_i (ls_req_valid_i),
        .accept_i   (accept),
        .grant_ls_o (grant_ls)
    );

    assign ls_req_ready_o = accept && grant_ls;
    assign if_req_ready_o = accept && !grant_ls;

    // Next-state, request latch and response capture.
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        req_d          = req_q;
        rsp_rdata_d    = rsp_rdata_q;
        if_rsp_valid_d = 1'b0;
        ls_rsp_valid_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d = ARB_ISSUE;
                    if (grant_ls) begin
                        src_d       = SRC_LSU;
                        req_d.addr  = MEM_ADDR_W'(ls_addr_i);
                        req_d.wdata = MEM_DATA_W'(ls_wdata_i);
                        req_d.we    = ls_we_i;
                        req_d.be    = MEM_BE_W'(ls_be_i);
                    end else begin
                        src_d       = SRC_IF;
                        req_d.addr  = MEM_ADDR_W'(if_addr_i);
                        req_d.wdata = '0;
                        req_d.we    = 1'b0;
                        req_d.be    = '1;
                    end
                end
            end
            ARB_ISSUE: begin
                if (bus_req_ready_i) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus_rsp_valid_i) begin
                    state_d        = ARB_IDLE;
                    rsp_rdata_d    = bus_rdata_i;
                    if_rsp_valid_d = (src_q == SRC_IF);
                    ls_rsp_valid_d = (src_q == SRC_LSU);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ARB_IDLE;
            src_q          <= SRC_IF;
            req_q          <= '0;
            rsp_rdata_q    <= '0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            req_q          <= req_d;
            rsp_rdata_q    <= rsp_rdata_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
        end
    end

    assign bus_req_valid_o = (state_q == ARB_ISSUE);
    assign bus_addr_o      = ADDR_W'(req_q.addr);
    assign bus_wdata_o     = DATA_W'(req_q.wdata);
    assign bus_we_o        = req_q.we;
    assign bus_be_o        = (DATA_W/8)'(req_q.be);
    assign rsp_rdata_o     = rsp_rdata_q;
    assign if_rsp_valid_o  = if_rsp_valid_q;
    assign ls_rsp_valid_o  = ls_rsp_valid_q;

endmodule
